// File: rtl/lc_1252_pkg.sv
// Shared types and helpers for the streaming odd-cell matrix engine.
package lc_1252_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SCAN,
    CALC,
    OUT
  } state_t;

  localparam logic MODE_ODD  = 1'b0;
  localparam logic MODE_EVEN = 1'b1;

  // Width needed to hold any dimension value from 0 up to max(max_m, max_n).
  function automatic int unsigned dim_w(input int unsigned max_m, input int unsigned max_n);
    int unsigned mx;
    mx = (max_m > max_n) ? max_m : max_n;
    return $clog2(mx + 1);
  endfunction

endpackage

// File: rtl/lc_1252_odd_matrix_par_if.sv
// Job/index stream in, count/err result out.
interface lc_1252_odd_matrix_par_if #(
  parameter int unsigned DIM_W = 6,
  parameter int unsigned CNT_W = 12
) ();

  logic [DIM_W-1:0]        m;
  logic [DIM_W-1:0]        n;
  logic                    mode;
  logic [1:0][DIM_W-1:0]   ind_tdata;
  logic                    ind_tvalid;
  logic                    ind_tlast;
  logic                    ind_tready;
  logic [CNT_W-1:0]        cell_cnt;
  logic                    err;
  logic                    out_tvalid;
  logic                    out_tready;

  modport master (
    output m, n, mode, ind_tdata, ind_tvalid, ind_tlast, out_tready,
    input  ind_tready, cell_cnt, err, out_tvalid
  );

  modport slave (
    input  m, n, mode, ind_tdata, ind_tvalid, ind_tlast, out_tready,
    output ind_tready, cell_cnt, err, out_tvalid
  );

endinterface

// File: rtl/lc_1252_odd_matrix_par_parity_scan.sv
// Row/column parity vectors plus the sequential scan that counts odd entries.
module parity_scan #(
  parameter int unsigned MAX_M = 50,
  parameter int unsigned MAX_N = 50,
  parameter int unsigned DIM_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tog_en,
  input  logic [DIM_W-1:0] tog_row,
  input  logic [DIM_W-1:0] tog_col,
  input  logic             clr,
  input  logic             scan_en,
  input  logic [DIM_W-1:0] m,
  input  logic [DIM_W-1:0] n,
  output logic [DIM_W-1:0] r_cnt,
  output logic [DIM_W-1:0] c_cnt,
  output logic             done_c
);

  logic [MAX_M-1:0] row_par;
  logic [MAX_N-1:0] col_par;
  logic [DIM_W-1:0] k;
  logic [DIM_W-1:0] len;
  logic             row_bit;
  logic             col_bit;

  // Scan length and the parity bits visible at the current index; indices past
  // the vector size only occur on jobs already flagged as erroneous.
  always_comb begin
    len     = (m > n) ? m : n;
    done_c  = scan_en && ((len == '0) || (k == len - DIM_W'(1)));
    row_bit = ((k < m) && (k < DIM_W'(MAX_M))) ? row_par[k] : 1'b0;
    col_bit = ((k < n) && (k < DIM_W'(MAX_N))) ? col_par[k] : 1'b0;
  end

  // Scan index runs only while scanning.
  always_ff @(posedge clk) begin
    if (rst || !scan_en) begin
      k <= '0;
    end else begin
      k <= k + DIM_W'(1);
    end
  end

  // Parity toggles during loading, odd-count accumulation during scanning.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      row_par <= '0;
      col_par <= '0;
      r_cnt   <= '0;
      c_cnt   <= '0;
    end else begin
      if (tog_en) begin
        row_par[tog_row] <= ~row_par[tog_row];
        col_par[tog_col] <= ~col_par[tog_col];
      end
      if (scan_en) begin
        r_cnt <= r_cnt + DIM_W'(row_bit);
        c_cnt <= c_cnt + DIM_W'(col_bit);
      end
    end
  end

endmodule

// File: rtl/lc_1252_odd_matrix_par.sv
// Streaming odd/even-cell counter: job control, error tracking and closed-form count.
module lc_1252_odd_matrix_par
  import lc_1252_pkg::*;
#(
  parameter int unsigned MAX_M = 50,
  parameter int unsigned MAX_N = 50,
  parameter int unsigned DIM_W = dim_w(MAX_M, MAX_N),
  parameter int unsigned CNT_W = $clog2(MAX_M * MAX_N + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  lc_1252_odd_matrix_par_if.slave    bus
);

  state_t           state;
  logic [DIM_W-1:0] m_q;
  logic [DIM_W-1:0] n_q;
  logic             mode_q;
  logic             err_reg;
  logic             ind_tready_q;
  logic             out_tvalid_q;
  logic [CNT_W-1:0] cell_cnt_q;
  logic             err_q;

  logic             accept;
  logic [DIM_W-1:0] eff_m;
  logic [DIM_W-1:0] eff_n;
  logic [DIM_W-1:0] row;
  logic [DIM_W-1:0] col;
  logic             dim_bad;
  logic             idx_bad;
  logic             tog_en;
  logic             scan_en;
  logic             clr;
  logic [DIM_W-1:0] r_cnt;
  logic [DIM_W-1:0] c_cnt;
  logic             scan_done;
  logic [DIM_W-1:0] n_minus_c;
  logic [DIM_W-1:0] m_minus_r;
  logic [CNT_W-1:0] odd_cnt;
  logic [CNT_W-1:0] even_cnt;

  assign bus.ind_tready = ind_tready_q;
  assign bus.out_tvalid = out_tvalid_q;
  assign bus.cell_cnt   = cell_cnt_q;
  assign bus.err        = err_q;

  // Beat qualification; the first beat of a job checks against the m/n being latched.
  always_comb begin
    accept    = bus.ind_tvalid && ind_tready_q;
    eff_m     = (state == IDLE) ? bus.m : m_q;
    eff_n     = (state == IDLE) ? bus.n : n_q;
    row       = bus.ind_tdata[0];
    col       = bus.ind_tdata[1];
    dim_bad   = (eff_m == '0) || (eff_n == '0) ||
                (eff_m > DIM_W'(MAX_M)) || (eff_n > DIM_W'(MAX_N));
    idx_bad   = (row >= eff_m) || (col >= eff_n);
    tog_en    = accept && !dim_bad && !idx_bad;
    scan_en   = (state == SCAN);
    clr       = (state == OUT) && bus.out_tready;
    n_minus_c = n_q - c_cnt;
    m_minus_r = m_q - r_cnt;
    odd_cnt   = CNT_W'(r_cnt) * CNT_W'(n_minus_c) + CNT_W'(m_minus_r) * CNT_W'(c_cnt);
    even_cnt  = CNT_W'(m_q) * CNT_W'(n_q) - odd_cnt;
  end

  parity_scan #(
    .MAX_M (MAX_M),
    .MAX_N (MAX_N),
    .DIM_W (DIM_W)
  ) u_scan (
    .clk     (clk),
    .rst     (rst),
    .tog_en  (tog_en),
    .tog_row (row),
    .tog_col (col),
    .clr     (clr),
    .scan_en (scan_en),
    .m       (m_q),
    .n       (n_q),
    .r_cnt   (r_cnt),
    .c_cnt   (c_cnt),
    .done_c  (scan_done)
  );

  // Job sequencing with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      m_q          <= '0;
      n_q          <= '0;
      mode_q       <= MODE_ODD;
      err_reg      <= 1'b0;
      ind_tready_q <= 1'b0;
      out_tvalid_q <= 1'b0;
      cell_cnt_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ind_tready_q <= 1'b1;
          if (accept) begin
            m_q    <= bus.m;
            n_q    <= bus.n;
            mode_q <= bus.mode;
            if (dim_bad || idx_bad) err_reg <= 1'b1;
            if (bus.ind_tlast) begin
              state        <= SCAN;
              ind_tready_q <= 1'b0;
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            if (dim_bad || idx_bad) err_reg <= 1'b1;
            if (bus.ind_tlast) begin
              state        <= SCAN;
              ind_tready_q <= 1'b0;
            end
          end
        end
        SCAN: begin
          if (scan_done) state <= CALC;
        end
        CALC: begin
          cell_cnt_q   <= err_reg ? '0 : ((mode_q == MODE_EVEN) ? even_cnt : odd_cnt);
          err_q        <= err_reg;
          out_tvalid_q <= 1'b1;
          state        <= OUT;
        end
        OUT: begin
          if (bus.out_tready) begin
            out_tvalid_q <= 1'b0;
            err_reg      <= 1'b0;
            ind_tready_q <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lc_1252_odd_matrix_par.sv
// Bench for the streaming odd-cell matrix engine, checked against a full-matrix model.
module tb_lc_1252_odd_matrix_par;

  localparam int unsigned DW = 6;
  localparam int unsigned CW = 12;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  lc_1252_odd_matrix_par_if #(.DIM_W(DW), .CNT_W(CW)) bus ();

  lc_1252_odd_matrix_par #(.MAX_M(50), .MAX_N(50)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: build the whole matrix cell by cell and count directly.
  function automatic void model(input int m, input int n, input int md,
                                input int rows[$], input int cols[$],
                                output int cnt, output bit e);
    int mat[50][50];
    cnt = 0;
    e   = (m == 0) || (n == 0) || (m > 50) || (n > 50);
    if (e) return;
    for (int i = 0; i < 50; i++)
      for (int j = 0; j < 50; j++) mat[i][j] = 0;
    for (int b = 0; b < rows.size(); b++) begin
      if (rows[b] >= m || cols[b] >= n) begin
        e = 1'b1;
      end else begin
        for (int j = 0; j < n; j++) mat[rows[b]][j]++;
        for (int i = 0; i < m; i++) mat[i][cols[b]]++;
      end
    end
    if (e) begin
      cnt = 0;
      return;
    end
    for (int i = 0; i < m; i++)
      for (int j = 0; j < n; j++)
        if ((mat[i][j] % 2) == (md ? 0 : 1)) cnt++;
  endfunction

  task automatic send_job(input int m, input int n, input int md,
                          input int rows[$], input int cols[$], input bit gaps);
    bus.m    = DW'(m);
    bus.n    = DW'(n);
    bus.mode = 1'(md);
    for (int i = 0; i < rows.size(); i++) begin
      int w;
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.ind_tvalid = 1'b0;
        @(negedge clk);
      end
      bus.ind_tdata[0] = DW'(rows[i]);
      bus.ind_tdata[1] = DW'(cols[i]);
      bus.ind_tlast    = (i == rows.size() - 1);
      bus.ind_tvalid   = 1'b1;
      w = 0;
      while (!bus.ind_tready && w < 100) begin
        @(negedge clk);
        w++;
      end
      if (w >= 100) begin
        n_cmp++;
        n_fail++;
        $display("FAIL accept_timeout: beat %0d not accepted within %0d cycles", i, w);
      end
      @(negedge clk);
    end
    bus.ind_tvalid = 1'b0;
    bus.ind_tlast  = 1'b0;
  endtask

  task automatic wait_result(output logic [CW-1:0] cnt, output logic e, output int lat);
    lat = 0;
    while (!bus.out_tvalid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.out_tvalid) begin
      n_cmp++;
      n_fail++;
      $display("FAIL result_timeout: out_tvalid got 0 want 1 after %0d cycles", lat);
    end
    cnt = bus.cell_cnt;
    e   = bus.err;
  endtask

  task automatic release_result();
    bus.out_tready = 1'b1;
    @(negedge clk);
    bus.out_tready = 1'b0;
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    bus.m          = '0;
    bus.n          = '0;
    bus.mode       = 1'b0;
    bus.ind_tdata  = '0;
    bus.ind_tvalid = 1'b0;
    bus.ind_tlast  = 1'b0;
    bus.out_tready = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.ind_tready !== 1'b0) begin
      n_fail++; $display("FAIL reset_tready: got %b want 0", bus.ind_tready);
    end
    n_cmp++;
    if (bus.out_tvalid !== 1'b0 || bus.err !== 1'b0 || bus.cell_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b err=%b cnt=%0d want 0/0/0",
               bus.out_tvalid, bus.err, bus.cell_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.ind_tready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_tready: got %b want 1", bus.ind_tready);
    end
  endtask

  task automatic test_basic();
    int rows[$];
    int cols[$];
    logic [CW-1:0] cnt;
    logic e;
    int lat;
    rows = '{0, 1};
    cols = '{1, 1};
    send_job(2, 3, 0, rows, cols, 1'b0);
    wait_result(cnt, e, lat);
    n_cmp++;
    if (cnt !== CW'(6) || e !== 1'b0) begin
      n_fail++; $display("FAIL basic_odd: got cnt=%0d err=%b want 6/0", cnt, e);
    end
    n_cmp++;
    if (lat != 4) begin
      n_fail++; $display("FAIL basic_latency: got %0d want 4", lat);
    end
    release_result();
    n_cmp++;
    if (bus.out_tvalid !== 1'b0 || bus.ind_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_rearm: got valid=%b tready=%b want 0/1", bus.out_tvalid, bus.ind_tready);
    end
    send_job(2, 3, 1, rows, cols, 1'b0);
    wait_result(cnt, e, lat);
    n_cmp++;
    if (cnt !== CW'(0) || e !== 1'b0) begin
      n_fail++; $display("FAIL basic_even: got cnt=%0d err=%b want 0/0", cnt, e);
    end
    release_result();
    rows = '{1, 0};
    cols = '{1, 0};
    send_job(2, 2, 0, rows, cols, 1'b0);
    wait_result(cnt, e, lat);
    n_cmp++;
    if (cnt !== CW'(0) || e !== 1'b0) begin
      n_fail++; $display("FAIL basic_2x2: got cnt=%0d err=%b want 0/0", cnt, e);
    end
    release_result();
  endtask

  task automatic test_hold();
    int rows[$];
    int cols[$];
    logic [CW-1:0] cnt;
    logic e;
    int lat;
    rows = '{0};
    cols = '{0};
    send_job(50, 50, 0, rows, cols, 1'b0);
    wait_result(cnt, e, lat);
    n_cmp++;
    if (cnt !== CW'(98) || e !== 1'b0 || lat != 51) begin
      n_fail++; $display("FAIL hold_result: got cnt=%0d err=%b lat=%0d want 98/0/51", cnt, e, lat);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.cell_cnt !== CW'(98) || bus.out_tvalid !== 1'b1 || bus.ind_tready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_stable: cycle %0d got cnt=%0d valid=%b tready=%b want 98/1/0",
                 i, bus.cell_cnt, bus.out_tvalid, bus.ind_tready);
      end
    end
    release_result();
  endtask

  task automatic test_err();
    int rows[$];
    int cols[$];
    logic [CW-1:0] cnt;
    logic e;
    int lat;
    rows = '{0, 5, 1};
    cols = '{1, 0, 1};
    send_job(2, 3, 0, rows, cols, 1'b0);
    wait_result(cnt, e, lat);
    n_cmp++;
    if (cnt !== CW'(0) || e !== 1'b1) begin
      n_fail++; $display("FAIL err_index: got cnt=%0d err=%b want 0/1", cnt, e);
    end
    release_result();
    rows = '{0, 1};
    cols = '{1, 1};
    send_job(2, 3, 0, rows, cols, 1'b0);
    wait_result(cnt, e, lat);
    n_cmp++;
    if (cnt !== CW'(6) || e !== 1'b0) begin
      n_fail++; $display("FAIL err_cleared: got cnt=%0d err=%b want 6/0", cnt, e);
    end
    release_result();
    rows = '{0};
    cols = '{0};
    send_job(0, 3, 0, rows, cols, 1'b0);
    wait_result(cnt, e, lat);
    n_cmp++;
    if (cnt !== CW'(0) || e !== 1'b1) begin
      n_fail++; $display("FAIL err_dim_zero: got cnt=%0d err=%b want 0/1", cnt, e);
    end
    release_result();
    send_job(51, 4, 1, rows, cols, 1'b0);
    wait_result(cnt, e, lat);
    n_cmp++;
    if (cnt !== CW'(0) || e !== 1'b1) begin
      n_fail++; $display("FAIL err_dim_big: got cnt=%0d err=%b want 0/1", cnt, e);
    end
    release_result();
  endtask

  task automatic test_reset_mid();
    int rows[$];
    int cols[$];
    logic [CW-1:0] cnt;
    logic e;
    int lat;
    int seen;
    rows = '{3};
    cols = '{7};
    send_job(50, 50, 0, rows, cols, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.out_tvalid !== 1'b0 || bus.ind_tready !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_during: got valid=%b tready=%b want 0/0", bus.out_tvalid, bus.ind_tready);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.ind_tready !== 1'b1) begin
      n_fail++; $display("FAIL midrst_tready: got %b want 1", bus.ind_tready);
    end
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus.out_tvalid !== 1'b0) seen++;
      @(negedge clk);
    end
    n_cmp++;
    if (seen != 0) begin
      n_fail++; $display("FAIL midrst_no_result: got %0d valid cycles want 0", seen);
    end
    rows = '{1, 0};
    cols = '{1, 0};
    send_job(2, 2, 0, rows, cols, 1'b0);
    wait_result(cnt, e, lat);
    n_cmp++;
    if (cnt !== CW'(0) || e !== 1'b0) begin
      n_fail++; $display("FAIL midrst_next_job: got cnt=%0d err=%b want 0/0", cnt, e);
    end
    release_result();
  endtask

  task automatic test_random();
    for (int j = 0; j < 25; j++) begin
      int m, n, md, nb, exp_cnt, lat, hold;
      bit exp_err, pre_ready;
      int rows[$];
      int cols[$];
      logic [CW-1:0] cnt;
      logic e;
      m  = $urandom_range(1, 50);
      n  = $urandom_range(1, 50);
      if ($urandom_range(0, 9) == 0) m = 55;
      if ($urandom_range(0, 9) == 0) n = 0;
      md = $urandom_range(0, 1);
      nb = $urandom_range(1, 10);
      for (int b = 0; b < nb; b++) begin
        int r, c;
        r = (m > 0) ? $urandom_range(0, m - 1) : 0;
        c = (n > 0) ? $urandom_range(0, n - 1) : 0;
        if ($urandom_range(0, 14) == 0) r = m;
        if ($urandom_range(0, 14) == 0) c = n;
        if ($urandom_range(0, 5) == 0 && b > 0) begin
          r = rows[0];
          c = cols[0];
        end
        rows.push_back(r);
        cols.push_back(c);
      end
      model(m, n, md, rows, cols, exp_cnt, exp_err);
      pre_ready = $urandom_range(0, 1);
      bus.out_tready = pre_ready;
      send_job(m, n, md, rows, cols, 1'b1);
      wait_result(cnt, e, lat);
      n_cmp++;
      if (cnt !== CW'(exp_cnt) || e !== exp_err) begin
        n_fail++;
        $display("FAIL rand_job%0d: m=%0d n=%0d mode=%0d got cnt=%0d err=%b want %0d/%b",
                 j, m, n, md, cnt, e, exp_cnt, exp_err);
      end
      if (!exp_err) begin
        n_cmp++;
        if (lat != ((m > n) ? m : n) + 1) begin
          n_fail++;
          $display("FAIL rand_latency%0d: got %0d want %0d", j, lat, ((m > n) ? m : n) + 1);
        end
      end
      if (!pre_ready) begin
        hold = $urandom_range(0, 3);
        repeat (hold) @(negedge clk);
        n_cmp++;
        if (bus.out_tvalid !== 1'b1 || bus.cell_cnt !== CW'(exp_cnt)) begin
          n_fail++;
          $display("FAIL rand_hold%0d: got valid=%b cnt=%0d want 1/%0d",
                   j, bus.out_tvalid, bus.cell_cnt, exp_cnt);
        end
      end
      release_result();
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_hold();
    test_err();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lc_1252_odd_matrix_par.md
Name: lc_1252_odd_matrix_par

Overview:
- Parametrised successor to the single-shot odd-cell matrix engine.
- Streams (row, col) increment indices over an AXI-Stream-like input and tracks per-row and per-column parity in bit-vectors instead of a full matrix RAM.
- Scans the parity vectors to count rows and columns with odd parity, then computes the odd-cell or even-cell count in closed form.
- Returns the count on a valid/ready output, then re-arms for the next job.

Parameters:
- MAX_M, 50, maximum row count supported.
- MAX_N, 50, maximum column count supported.
- DIM_W, $clog2(max(MAX_M,MAX_N)+1), width of m, n and index fields.
- CNT_W, $clog2(MAX_M*MAX_N+1), width of the result count.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- m  in  DIM_W  row count; sampled on the first accepted beat of a job.
- n  in  DIM_W  column count; sampled on the first accepted beat of a job.
- mode  in  1  0 = count odd cells, 1 = count even cells; sampled with m/n.
- ind_tdata  in  2*DIM_W  packed [1:0][DIM_W-1:0]; [0] = row, [1] = col.
- ind_tvalid  in  1  index beat valid.
- ind_tlast  in  1  last index of the job.
- ind_tready  out  1  block accepts index beats.
- cell_cnt  out  CNT_W  result count.
- err  out  1  job had an illegal dimension or out-of-range index; valid alongside out_tvalid.
- out_tvalid  out  1  result valid.
- out_tready  in  1  result consumer ready.

Behaviour:
- Reset values:
  - ind_tready=0 while rst is high, 1 in the first cycle after reset.
  - cell_cnt=0, err=0, out_tvalid=0.
  - Parity vectors, counters and the latched m/n/mode are all cleared.
  - State goes to IDLE.
- Beat acceptance: a beat is accepted when ind_tvalid && ind_tready on a clk edge.
- States: IDLE, LOAD, SCAN, CALC, OUT.
- IDLE:
  - ind_tready=1.
  - On an accepted beat: latch m, n, mode; process the beat; go to LOAD, or to SCAN if tlast is set.
- LOAD:
  - ind_tready=1.
  - Each accepted beat toggles row_par[row] and col_par[col].
  - tlast on an accepted beat moves to SCAN.
  - There is no limit on beats per job.
- Index check:
  - A beat with row>=m or col>=n toggles nothing and sets the sticky err_reg.
  - Dimension check uses the m/n latched for the job, including on the first beat.
- Dimension check: latched m==0, n==0, m>MAX_M or n>MAX_N sets err_reg. The job still completes with cell_cnt=0.
- SCAN:
  - ind_tready=0.
  - Index k runs from 0 to L-1, where L=max(m,n).
  - Each cycle: R += row_par[k] when k<m; C += col_par[k] when k<n.
  - Takes exactly L cycles.
- CALC, one cycle:
  - odd = R*(n-C) + (m-R)*C.
  - even = m*n - odd.
  - cell_cnt <= mode ? even : odd, forced to 0 if err_reg is set.
  - err <= err_reg.
- OUT:
  - out_tvalid=1; cell_cnt and err stay stable until out_tready.
  - On handshake: out_tvalid<=0; clear row_par, col_par, R, C, err_reg in the same edge; go to IDLE.
  - ind_tready stays 0 throughout OUT, so a new job cannot overlap.
- Latency: out_tvalid rises L+1 cycles after the edge accepting tlast.
- Width rules:
  - R and C are DIM_W wide.
  - Products are CNT_W wide and use unsigned arithmetic.
  - No overflow is possible within the parameter limits.
- Repeated index: toggling twice restores parity, which is correct by construction.
- Reset mid-operation: an rst in any state aborts the job, discards the partial result and returns to the reset values the next cycle.
- out_tready held high before valid: it has no effect outside OUT.

Decomposition:
- Package lc_1252_pkg:
  - State enum (IDLE, LOAD, SCAN, CALC, OUT).
  - Function dim_w(max_m, max_n).
  - MODE_ODD/MODE_EVEN constants.
- One sub-module, parity_scan:
  - Holds row_par/col_par, toggle and clear inputs.
  - Sequential k-counter producing R, C and a done pulse.
- The top level holds the FSM, the latched m/n/mode, error tracking and the CALC arithmetic.

Test Plan:
- m=2, n=3, mode=0, indices [0,1],[1,1] (tlast on the 2nd) -> cell_cnt=6, err=0, out_tvalid exactly 4 cycles after the tlast edge (L=3).
- Same indices, mode=1 -> cell_cnt=0.
- m=2, n=2, indices [1,1],[0,0] -> cell_cnt=0.
- m=50, n=50, single index [0,0] with tlast -> cell_cnt=98. Hold out_tready=0 for 10 cycles: cell_cnt stable, ind_tready=0.
- m=2, n=3, indices [0,1],[5,0],[1,1] -> err=1, cell_cnt=0. The next job (2x3, [0,1],[1,1]) -> 6 with err=0, proving the clear.
- Assert rst during SCAN of a 50x50 job -> out_tvalid stays 0, ind_tready=1 the cycle after rst deasserts. A following 2x2 [1,1],[0,0] job -> 0.
